trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: CSR file, interrupt/exception arbitration and the
// trap redirect handshake towards the fetch stage.
module trap_ctrl #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [31:0]        pc_i,
    input  logic               meip_i,
    input  logic               mtip_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               exc_valid_i,
    input  logic [3:0]         exc_cause_i,
    input  logic [31:0]        exc_tval_i,
    input  logic               mret_i,
    input  logic               csr_we_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [31:0]        csr_wdata_i,
    output logic [31:0]        csr_rdata_o,
    output logic               trap_o,
    output logic [31:0]        trap_pc_o,
    input  logic               trap_ready_i,
    output logic [31:0]        mepc_o,
    output logic [NUM_IRQ-1:0] irq_ack_o
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [31:0] MIE_MASK   = (((32'h1 << NUM_IRQ) - 32'h1) << 16) | 32'h0000_0880;

    typedef enum logic {IDLE, REQ} state_e;

    state_e             state_q, state_d;
    logic               mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [31:0]        mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0]        mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d, mip_q, mip_d;
    logic [63:0]        mcycle_q, mcycle_d;
    logic [31:0]        trap_pc_q, trap_pc_d, rdata_q, rdata_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;
    logic [31:0]        lat_pc_q, lat_pc_d, lat_cause_q, lat_cause_d, lat_tval_q, lat_tval_d;
    logic [NUM_IRQ-1:0] lat_ack_q, lat_ack_d;

    logic [31:0]        pend;
    logic               int_req;
    logic [4:0]         int_code;
    logic [NUM_IRQ-1:0] int_ack;
    logic [31:0]        mtvec_base;

    assign mtvec_base = {mtvec_q[31:2], 2'b00};

    // Lowest platform line wins among platform lines; MTI and MEI override in turn.
    always_comb begin
        pend     = mip_q & mie_q & {32{mst_mie_q}};
        int_req  = |pend;
        int_code = 5'd0;
        int_ack  = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (pend[16+k]) begin
                int_code   = 5'(16 + k);
                int_ack    = '0;
                int_ack[k] = 1'b1;
            end
        end
        if (pend[7]) begin
            int_code = 5'd7;
            int_ack  = '0;
        end
        if (pend[11]) begin
            int_code = 5'd11;
            int_ack  = '0;
        end
    end

    always_comb begin
        rdata_d = 32'h0;
        case (csr_addr_i)
            A_MSTATUS:  rdata_d = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            A_MIE:      rdata_d = mie_q;
            A_MTVEC:    rdata_d = mtvec_q;
            A_MSCRATCH: rdata_d = mscratch_q;
            A_MEPC:     rdata_d = mepc_q;
            A_MCAUSE:   rdata_d = mcause_q;
            A_MTVAL:    rdata_d = mtval_q;
            A_MIP:      rdata_d = mip_q;
            A_MCYCLE:   rdata_d = mcycle_q[31:0];
            A_MCYCLEH:  rdata_d = mcycle_q[63:32];
            default:    rdata_d = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mst_mie_d   = mst_mie_q;
        mst_mpie_d  = mst_mpie_q;
        mie_d       = mie_q;
        mtvec_d     = mtvec_q;
        mscratch_d  = mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        mcycle_d    = mcycle_q + 64'd1;
        trap_pc_d   = trap_pc_q;
        ack_d       = '0;
        lat_pc_d    = lat_pc_q;
        lat_cause_d = lat_cause_q;
        lat_tval_d  = lat_tval_q;
        lat_ack_d   = lat_ack_q;
        mip_d       = 32'h0;
        mip_d[11]   = meip_i;
        mip_d[7]    = mtip_i;
        mip_d[16 +: NUM_IRQ] = irq_i;

        if (csr_we_i) begin
            case (csr_addr_i)
                A_MSTATUS: begin
                    mst_mie_d  = csr_wdata_i[3];
                    mst_mpie_d = csr_wdata_i[7];
                end
                A_MIE:      mie_d      = csr_wdata_i & MIE_MASK;
                A_MTVEC:    mtvec_d    = (csr_wdata_i[1:0] >= 2'd2) ?
                                         {csr_wdata_i[31:2], mtvec_q[1:0]} : csr_wdata_i;
                A_MSCRATCH: mscratch_d = csr_wdata_i;
                A_MEPC:     mepc_d     = {csr_wdata_i[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = csr_wdata_i;
                A_MTVAL:    mtval_d    = csr_wdata_i;
                A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], csr_wdata_i};
                A_MCYCLEH:  mcycle_d   = {csr_wdata_i, mcycle_q[31:0]};
                default: ;
            endcase
        end

        if (state_q == IDLE) begin
            if (mret_i) begin
                mst_mie_d  = mst_mpie_q;
                mst_mpie_d = 1'b1;
            end
            if (int_req || exc_valid_i) begin
                state_d  = REQ;
                lat_pc_d = pc_i;
                if (int_req) begin
                    lat_cause_d = {1'b1, 26'b0, int_code};
                    lat_tval_d  = 32'h0;
                    lat_ack_d   = int_ack;
                    trap_pc_d   = mtvec_base +
                                  ((mtvec_q[1:0] == 2'b01) ? {25'b0, int_code, 2'b00} : 32'h0);
                end else begin
                    lat_cause_d = {28'b0, exc_cause_i};
                    lat_tval_d  = exc_tval_i;
                    lat_ack_d   = '0;
                    trap_pc_d   = mtvec_base;
                end
            end
        end else if (trap_ready_i) begin
            // Commit: trap-owned CSR fields override any CSR write this cycle.
            state_d    = IDLE;
            mepc_d     = {lat_pc_q[31:2], 2'b00};
            mcause_d   = lat_cause_q;
            mtval_d    = lat_tval_q;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            ack_d      = lat_ack_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= 32'h0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            mip_q      <= 32'h0;
            mcycle_q   <= 64'h0;
            trap_pc_q  <= 32'h0;
            rdata_q    <= 32'h0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
            mcycle_q   <= mcycle_d;
            trap_pc_q  <= trap_pc_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
        end
    end

    // Latched trap payload is only consumed from REQ, so it needs no reset.
    always_ff @(posedge clk_i) begin
        lat_pc_q    <= lat_pc_d;
        lat_cause_q <= lat_cause_d;
        lat_tval_q  <= lat_tval_d;
        lat_ack_q   <= lat_ack_d;
    end

    assign trap_o      = (state_q == REQ);
    assign trap_pc_o   = trap_pc_q;
    assign mepc_o      = mepc_q;
    assign irq_ack_o   = ack_q;
    assign csr_rdata_o = rdata_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios and randomized traffic checked every
// cycle against a transaction-level reference model.
module tb_trap_ctrl;
    localparam int          NUM_IRQ     = 4;
    localparam logic [31:0] RESET_MTVEC = 32'h0000_0000;

    logic               clk_i = 1'b0;
    logic               reset_i = 1'b0;
    logic [31:0]        pc_i = '0;
    logic               meip_i = 1'b0, mtip_i = 1'b0;
    logic [NUM_IRQ-1:0] irq_i = '0;
    logic               exc_valid_i = 1'b0;
    logic [3:0]         exc_cause_i = '0;
    logic [31:0]        exc_tval_i = '0;
    logic               mret_i = 1'b0;
    logic               csr_we_i = 1'b0;
    logic [11:0]        csr_addr_i = '0;
    logic [31:0]        csr_wdata_i = '0;
    logic [31:0]        csr_rdata_o;
    logic               trap_o;
    logic [31:0]        trap_pc_o;
    logic               trap_ready_i = 1'b0;
    logic [31:0]        mepc_o;
    logic [NUM_IRQ-1:0] irq_ack_o;

    trap_ctrl #(.NUM_IRQ(NUM_IRQ), .RESET_MTVEC(RESET_MTVEC)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .pc_i(pc_i), .meip_i(meip_i), .mtip_i(mtip_i),
        .irq_i(irq_i), .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_tval_i(exc_tval_i), .mret_i(mret_i), .csr_we_i(csr_we_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
        .trap_o(trap_o), .trap_pc_o(trap_pc_o), .trap_ready_i(trap_ready_i),
        .mepc_o(mepc_o), .irq_ack_o(irq_ack_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model: architectural CSR state plus an outstanding-trap queue.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] target;
        int          line;
    } trap_t;

    bit                 r_mie, r_mpie;
    logic [31:0]        r_miereg, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_mip;
    logic [63:0]        r_cycle;
    logic [31:0]        r_rdata;
    logic [NUM_IRQ-1:0] r_ack;
    trap_t              pending[$];

    function automatic logic [31:0] mie_mask();
        logic [31:0] m = 32'h0;
        m[11] = 1'b1;
        m[7]  = 1'b1;
        for (int k = 0; k < NUM_IRQ; k++) m[16+k] = 1'b1;
        return m;
    endfunction

    // Priority list: MEI, MTI, then platform lines in ascending order.
    function automatic int prio_code(input int i);
        if (i == 0) return 11;
        if (i == 1) return 7;
        return 16 + i - 2;
    endfunction

    function automatic void model_reset();
        r_mie = 0; r_mpie = 0;
        r_miereg = 0; r_mtvec = RESET_MTVEC; r_mscratch = 0;
        r_mepc = 0; r_mcause = 0; r_mtval = 0; r_mip = 0;
        r_cycle = 0; r_rdata = 0; r_ack = '0;
        pending.delete();
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (r_mpie ? 32'h80 : 32'h0) | (r_mie ? 32'h8 : 32'h0);
            12'h304: return r_miereg;
            12'h305: return r_mtvec;
            12'h340: return r_mscratch;
            12'h341: return r_mepc;
            12'h342: return r_mcause;
            12'h343: return r_mtval;
            12'h344: return r_mip;
            12'hB00: return r_cycle[31:0];
            12'hB80: return r_cycle[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_step();
        bit          pre_mie = r_mie, pre_mpie = r_mpie;
        bit          was_idle = (pending.size() == 0);
        bit          enter = 0;
        trap_t       t;
        logic [31:0] en, w;
        int          code;
        r_rdata = model_read(csr_addr_i);
        r_ack = '0;
        t = '{pc: 0, cause: 0, tval: 0, target: 0, line: -1};
        if (was_idle) begin
            en = r_mip & r_miereg;
            if (pre_mie) begin
                for (int i = 0; i < NUM_IRQ + 2; i++) begin
                    code = prio_code(i);
                    if (!enter && en[code]) begin
                        enter = 1;
                        t.cause = 32'h8000_0000 + 32'(code);
                        t.tval = 0;
                        t.line = (code >= 16) ? code - 16 : -1;
                    end
                end
            end
            if (!enter && exc_valid_i) begin
                enter = 1;
                t.cause = 32'(exc_cause_i);
                t.tval = exc_tval_i;
                t.line = -1;
            end
            if (enter) begin
                t.pc = pc_i;
                t.target = (r_mtvec & ~32'h3);
                if (r_mtvec[1:0] == 2'd1 && t.cause[31]) t.target += 4 * (t.cause & 32'h1F);
            end
        end
        w = csr_wdata_i;
        if (csr_we_i) begin
            case (csr_addr_i)
                12'h300: begin r_mie = w[3]; r_mpie = w[7]; end
                12'h304: r_miereg = w & mie_mask();
                12'h305: r_mtvec = (w[1:0] >= 2) ? ((w & ~32'h3) | (r_mtvec & 32'h3)) : w;
                12'h340: r_mscratch = w;
                12'h341: r_mepc = w & ~32'h3;
                12'h342: r_mcause = w;
                12'h343: r_mtval = w;
                default: ;
            endcase
        end
        if (csr_we_i && csr_addr_i == 12'hB00)      r_cycle[31:0] = w;
        else if (csr_we_i && csr_addr_i == 12'hB80) r_cycle[63:32] = w;
        else                                        r_cycle = r_cycle + 1;
        r_mip = 0;
        r_mip[11] = meip_i;
        r_mip[7] = mtip_i;
        for (int k = 0; k < NUM_IRQ; k++) r_mip[16+k] = irq_i[k];
        if (!was_idle && trap_ready_i) begin
            t = pending.pop_front();
            r_mepc = t.pc & ~32'h3;
            r_mcause = t.cause;
            r_mtval = t.tval;
            r_mpie = pre_mie;
            r_mie = 0;
            if (t.line >= 0) r_ack[t.line] = 1'b1;
        end else if (was_idle) begin
            if (mret_i) begin r_mie = pre_mpie; r_mpie = 1; end
            if (enter) pending.push_back(t);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("trap_o", {31'b0, trap_o}, (pending.size() > 0) ? 32'h1 : 32'h0);
        if (pending.size() > 0) check("trap_pc_o", trap_pc_o, pending[0].target);
        check("mepc_o", mepc_o, r_mepc);
        check("irq_ack_o", 32'(irq_ack_o), 32'(r_ack));
        check("csr_rdata_o", csr_rdata_o, r_rdata);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
        tick();
        csr_we_i = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        csr_addr_i = a;
        tick();
        d = csr_rdata_o;
    endtask

    task automatic wait_trap();
        for (int n = 0; n < 20 && !trap_o; n++) tick();
        check("trap_wait", {31'b0, trap_o}, 32'h1);
    endtask

    task automatic hold_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    task automatic mcyc_wrap(input logic [31:0] hi, input logic [11:0] a,
                             input logic [31:0] exp, input string tag);
        logic [31:0] v;
        csr_wr(12'hB80, hi);
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        csr_rd(a, v);
        check(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [11:0] addrs[12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h301};
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        check("rst trap_o", {31'b0, trap_o}, 32'h0);
        check("rst irq_ack_o", 32'(irq_ack_o), 32'h0);
        check("rst csr_rdata_o", csr_rdata_o, 32'h0);
        check("rst trap_pc_o", trap_pc_o, 32'h0);
        hold_reset();

        // Vectored platform interrupt on line 2.
        csr_wr(12'h305, 32'h0000_1001);
        csr_wr(12'h304, 32'h1 << 18);
        csr_wr(12'h300, 32'h8);
        irq_i = 4'b0100;
        wait_trap();
        check("irq2 trap_pc", trap_pc_o, 32'h0000_1048);
        trap_ready_i = 1'b1;
        tick();
        trap_ready_i = 1'b0;
        check("irq2 ack", 32'(irq_ack_o), 32'h4);
        irq_i = '0;
        csr_rd(12'h342, v); check("irq2 mcause", v, 32'h8000_0012);
        csr_rd(12'h300, v); check("irq2 mstatus", v, 32'h0000_1880);

        // Synchronous exception; inputs change after entry and must not leak in.
        exc_valid_i = 1'b1; exc_cause_i = 4'd2; pc_i = 32'h200; exc_tval_i = 32'hDEAD;
        tick();
        exc_valid_i = 1'b0; pc_i = 32'h1234; exc_tval_i = 32'h0;
        check("exc trap_o", {31'b0, trap_o}, 32'h1);
        check("exc trap_pc", trap_pc_o, 32'h0000_1000);
        trap_ready_i = 1'b1;
        tick();
        trap_ready_i = 1'b0;
        csr_rd(12'h341, v); check("exc mepc", v, 32'h200);
        csr_rd(12'h342, v); check("exc mcause", v, 32'h2);
        csr_rd(12'h343, v); check("exc mtval", v, 32'h0000_DEAD);

        // MTI beats platform lines 0 and 3; line 0 follows after mret.
        csr_wr(12'h304, (32'h1 << 7) | (32'h1 << 16) | (32'h1 << 19));
        irq_i = 4'b1001; mtip_i = 1'b1;
        csr_wr(12'h300, 32'h8);
        wait_trap();
        check("prio trap_pc mti", trap_pc_o, 32'h0000_101C);
        trap_ready_i = 1'b1; tick(); trap_ready_i = 1'b0;
        csr_rd(12'h342, v); check("prio mcause mti", v, 32'h8000_0007);
        mtip_i = 1'b0; mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        wait_trap();
        check("prio trap_pc irq0", trap_pc_o, 32'h0000_1040);
        trap_ready_i = 1'b1; tick(); trap_ready_i = 1'b0;
        check("prio ack irq0", 32'(irq_ack_o), 32'h1);
        csr_rd(12'h342, v); check("prio mcause irq0", v, 32'h8000_0010);

        // Request held through five stalled cycles while the line drops.
        irq_i = 4'b0001;
        csr_wr(12'h300, 32'h8);
        wait_trap();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall trap_o", {31'b0, trap_o}, 32'h1);
            check("stall trap_pc", trap_pc_o, 32'h0000_1040);
            if (i == 0) irq_i = '0;
        end
        trap_ready_i = 1'b1; tick(); trap_ready_i = 1'b0;
        check("stall commit trap_o", {31'b0, trap_o}, 32'h0);
        check("stall commit ack", 32'(irq_ack_o), 32'h1);

        // 64-bit cycle counter carry and full wrap.
        mcyc_wrap(32'h0, 12'hB80, 32'h1, "mcycleh carry");
        mcyc_wrap(32'h0, 12'hB00, 32'h0, "mcycle carry");
        mcyc_wrap(32'hFFFF_FFFF, 12'hB80, 32'h0, "mcycleh wrap");

        // Reset in REQ aborts the trap asynchronously.
        irq_i = 4'b0001;
        csr_wr(12'h300, 32'h8);
        wait_trap();
        #3 reset_i = 1'b1;
        #1;
        model_reset();
        check("abort trap_o", {31'b0, trap_o}, 32'h0);
        check("abort irq_ack", 32'(irq_ack_o), 32'h0);
        check("abort mepc_o", mepc_o, 32'h0);
        irq_i = '0;
        hold_reset();
        csr_rd(12'h342, v); check("abort mcause", v, 32'h0);
        csr_rd(12'h300, v); check("abort mstatus", v, 32'h0000_1800);
        csr_rd(12'h305, v); check("abort mtvec", v, RESET_MTVEC);

        // CSR corner cases: mtvec mode protection, mie mask, read-before-write.
        csr_wr(12'h305, 32'h0000_1001);
        csr_wr(12'h305, 32'h0000_2002);
        csr_rd(12'h305, v); check("mtvec mode keep", v, 32'h0000_2001);
        csr_wr(12'h304, 32'hFFFF_FFFF);
        csr_rd(12'h304, v); check("mie mask", v, 32'h000F_0880);
        csr_wr(12'h340, 32'h1111);
        csr_wr(12'h340, 32'h2222);
        check("rdata old value", csr_rdata_o, 32'h1111);
        csr_rd(12'h340, v); check("rdata new value", v, 32'h2222);
        csr_rd(12'h7C0, v); check("unmapped read", v, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) irq_i = NUM_IRQ'($urandom);
            if ($urandom_range(0, 15) == 0) meip_i = ~meip_i;
            if ($urandom_range(0, 15) == 0) mtip_i = ~mtip_i;
            exc_valid_i  = ($urandom_range(0, 5) == 0);
            exc_cause_i  = 4'($urandom);
            exc_tval_i   = $urandom;
            pc_i         = $urandom;
            trap_ready_i = $urandom_range(0, 1) == 1;
            mret_i       = ($urandom_range(0, 15) == 0);
            csr_addr_i   = addrs[$urandom_range(0, 11)];
            csr_we_i     = ($urandom_range(0, 3) == 0);
            csr_wdata_i  = $urandom;
            if (csr_addr_i == 12'h300)
                csr_wdata_i = ($urandom & 32'h88) | (($urandom_range(0, 3) != 0) ? 32'h8 : 32'h0);
            if (csr_addr_i == 12'h304 && $urandom_range(0, 1) == 1) csr_wdata_i = 32'hFFFF_FFFF;
            if (mret_i && csr_addr_i == 12'h300) csr_we_i = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
